// File: rtl/button_irq_wb8.sv
// button_irq_wb8: Wishbone slave that conditions raw push buttons.
// Pipeline: 2-flop synchroniser -> 1 ms tick debounce -> press/release capture,
// with a level interrupt from enabled press flags.
module button_irq_wb8 #(
  parameter int unsigned NBUTTONS    = 5,
  parameter int unsigned CLOCKFREQ   = 25125000,
  parameter int unsigned DEBOUNCE_MS = 8
) (
  input  logic                I_wb_clk,
  input  logic                I_reset,
  input  logic [1:0]          I_wb_adr,
  input  logic [7:0]          I_wb_dat,
  input  logic                I_wb_stb,
  input  logic                I_wb_we,
  output logic [7:0]          O_wb_dat,
  output logic                O_wb_ack,
  input  logic [NBUTTONS-1:0] I_button,
  output logic                O_interrupt
);

  localparam int unsigned PRESC_DIV = CLOCKFREQ / 1000;
  localparam int unsigned PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam int unsigned CNT_W     = 4;

  localparam logic [1:0] ADR_STATE   = 2'd0;
  localparam logic [1:0] ADR_PRESS   = 2'd1;
  localparam logic [1:0] ADR_RELEASE = 2'd2;
  localparam logic [1:0] ADR_IE      = 2'd3;

  logic [NBUTTONS-1:0]            r_sync1;
  logic [NBUTTONS-1:0]            r_sync2;
  logic [PRESC_W-1:0]             r_presc;
  logic [NBUTTONS-1:0][CNT_W-1:0] r_cnt;
  logic [NBUTTONS-1:0]            r_stable;
  logic [NBUTTONS-1:0]            r_press;
  logic [NBUTTONS-1:0]            r_release;
  logic [NBUTTONS-1:0]            r_ie;
  logic                           r_ack;
  logic [7:0]                     r_dat;
  logic                           r_irq;

  logic                           w_tick;
  logic [NBUTTONS-1:0][CNT_W-1:0] w_cnt_nxt;
  logic [NBUTTONS-1:0]            w_stable_nxt;
  logic [NBUTTONS-1:0]            w_rise;
  logic [NBUTTONS-1:0]            w_fall;
  logic                           w_access;
  logic                           w_wr;
  logic [NBUTTONS-1:0]            w_clr_press;
  logic [NBUTTONS-1:0]            w_clr_release;
  logic [7:0]                     w_rdata;
  logic                           w_unused_dat;

  assign O_wb_dat    = r_dat;
  assign O_wb_ack    = r_ack;
  assign O_interrupt = r_irq;

  // Upper write-data bits are meaningless when fewer than 8 buttons exist.
  assign w_unused_dat = ^I_wb_dat;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= I_button;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_presc == PRESC_W'(PRESC_DIV - 1));

  // 1 ms prescaler: tick on terminal count, then wrap.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end

  // Debounce: a level change is accepted after DEBOUNCE_MS consecutive differing ticks.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    for (int i = 0; i < NBUTTONS; i++) begin
      if (w_tick) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_cnt[i] == CNT_W'(DEBOUNCE_MS - 1)) begin
            w_stable_nxt[i] = ~r_stable[i];
            w_cnt_nxt[i]    = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt[i] = '0;
        end
      end
    end
  end

  assign w_rise = w_stable_nxt & ~r_stable;
  assign w_fall = ~w_stable_nxt & r_stable;

  // Bus decode: one access per strobe, spaced by the registered ack.
  assign w_access      = I_wb_stb & ~r_ack;
  assign w_wr          = w_access & I_wb_we;
  assign w_clr_press   = (w_wr && (I_wb_adr == ADR_PRESS))   ? I_wb_dat[NBUTTONS-1:0] : '0;
  assign w_clr_release = (w_wr && (I_wb_adr == ADR_RELEASE)) ? I_wb_dat[NBUTTONS-1:0] : '0;

  // Read mux; unimplemented bits read as zero.
  always_comb begin
    w_rdata = 8'h00;
    case (I_wb_adr)
      ADR_STATE:   w_rdata = 8'(r_stable);
      ADR_PRESS:   w_rdata = 8'(r_press);
      ADR_RELEASE: w_rdata = 8'(r_release);
      ADR_IE:      w_rdata = 8'(r_ie);
      default:     w_rdata = 8'h00;
    endcase
  end

  // Debounce state and sticky edge flags; a new edge beats a same-cycle clear.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      r_cnt     <= '0;
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_stable  <= w_stable_nxt;
      r_press   <= (r_press & ~w_clr_press) | w_rise;
      r_release <= (r_release & ~w_clr_release) | w_fall;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      r_ie <= '0;
    end else if (w_wr && (I_wb_adr == ADR_IE)) begin
      r_ie <= I_wb_dat[NBUTTONS-1:0];
    end
  end

  // Registered ack, read data and interrupt.
  always_ff @(posedge I_wb_clk or posedge I_reset) begin
    if (I_reset) begin
      r_ack <= 1'b0;
      r_dat <= 8'h00;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_access;
      r_dat <= w_access ? w_rdata : 8'h00;
      r_irq <= |(r_press & r_ie);
    end
  end

endmodule

// File: doc/button_irq_wb8.md
Name: button_irq_wb8

Overview:
- 8-bit Wishbone slave that conditions raw push-button inputs before software reads them.
- Function chain: synchroniser, then debounce filter, then press/release edge capture with interrupt generation.
- Sits between the board button pins and the SoC bus arbiter.
- Provides debounced button state and latched edge flags, so software need not poll fast.
- Its interrupt output can be ORed with the timer interrupt at the CPU.

Parameters:
- NBUTTONS, 5, number of button inputs (1..8).
- CLOCKFREQ, 25125000, clock frequency in Hz; used to derive the 1 ms sample tick.
- DEBOUNCE_MS, 8, consecutive 1 ms samples required to accept a level change (1..15).

Ports:
- I_wb_clk  in  1  system clock.
- I_reset  in  1  asynchronous, active-high reset.
- I_wb_adr  in  2  register select.
- I_wb_dat  in  8  write data.
- I_wb_stb  in  1  bus strobe (slave selected by arbiter).
- I_wb_we  in  1  write enable.
- O_wb_dat  out  8  read data.
- O_wb_ack  out  1  transfer acknowledge.
- I_button  in  NBUTTONS  raw button levels, active high, asynchronous to clock.
- O_interrupt  out  1  level interrupt, active high.

Behaviour:
- Reset (async, I_reset=1): all registers cleared.
  - Outputs: O_wb_ack=0, O_wb_dat=0, O_interrupt=0.
  - State: stable=0, press=0, release=0, ie=0, prescaler=0, debounce counters=0, synchroniser flops=0.
- Synchroniser: 2 flops per button; debounce logic sees only the second flop.
- Prescaler:
  - Counts 0..CLOCKFREQ/1000-1.
  - Emits a one-cycle tick on terminal count, then wraps to 0.
- Debounce, per button, on each tick:
  - If sync != stable: counter increments.
  - If sync == stable: counter clears to 0.
  - When counter reaches DEBOUNCE_MS-1 and sync still differs: stable toggles, counter clears.
  - Result: acceptance after exactly DEBOUNCE_MS consecutive differing ticks.
  - A single agreeing sample restarts the count.
- Edge capture:
  - stable 0->1 sets press[i].
  - stable 1->0 sets release[i].
  - Flags are sticky until cleared.
- Register map (bits >= NBUTTONS read 0 and ignore writes):
  - adr 0: STATE, read-only, debounced stable levels. Writes ignored.
  - adr 1: PRESS flags. Read returns flags; write-1-to-clear per bit.
  - adr 2: RELEASE flags. Read returns flags; write-1-to-clear per bit.
  - adr 3: IE, read/write. Bits [NBUTTONS-1:0] enable interrupt from the press flags.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins, flag stays 1.
- Bus handshake:
  - O_wb_ack is registered: O_wb_ack <= I_wb_stb & ~O_wb_ack.
  - Gives one-cycle latency and a single ack pulse per strobe.
  - Held-high stb yields ack every second cycle.
  - O_wb_dat is registered in the same cycle as ack, valid while ack=1.
  - Write side effects occur in the cycle ack is generated; exactly one effect per transfer.
- Interrupt:
  - O_interrupt <= |(press & ie), registered.
  - Deasserts the cycle after the last enabled press flag is cleared or its ie bit is cleared.
  - Release flags never interrupt.
- Reset mid-debounce or mid-transfer:
  - Everything returns to reset values immediately.
  - No ack is emitted for an aborted strobe.
  - After reset release, a button already held high is accepted after DEBOUNCE_MS ticks and sets press.

Test Plan:
Bench uses CLOCKFREQ=10000 (tick every 10 cycles), DEBOUNCE_MS=3, NBUTTONS=5.
1. Clean press: I_button=5'b00001 held.
   - STATE reads 0x01 within 2+30 (+10 alignment) cycles; PRESS reads 0x01; O_interrupt stays 0 (IE=0).
2. Bounce rejection: button0 toggles every 15 cycles for 200 cycles, then settles at 0.
   - STATE stays 0x00; PRESS=RELEASE=0x00.
3. Interrupt flow: write IE=0x03, press button1.
   - O_interrupt rises one cycle after press[1] sets.
   - Write PRESS=0x02: O_interrupt falls next cycle; PRESS reads 0x00.
4. Set/clear collision: issue W1C to PRESS bit0 on the exact cycle stable[0] rises.
   - PRESS reads 0x01 afterwards.
5. Release and masking: press then release button4 with IE=0x10.
   - RELEASE reads 0x10; O_interrupt tracks press only.
   - Writes to STATE have no effect; reads of bits [7:5] are 0.
6. Async reset mid-debounce: assert I_reset for 1 cycle, 2 ticks into an acceptance.
   - All registers read 0; no ack pulse; acceptance restarts, completing 3 ticks after release.
